// File: rtl/clk_div_ctrl.sv
// Run-time controller for the even-ratio clock divider: owns the half-period
// counter and a valid/ready port for re-programming the ratio at period boundaries.
module clk_div_ctrl #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_half_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             period_done_o,
    output logic             running_o,
    output logic             pending_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             pdone_q, pdone_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             toggle;
    logic             fall;

    assign xfer = cfg_valid_i & ~pending_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        clk_out_d = clk_out_q;
        toggle    = 1'b0;
        fall      = 1'b0;
        err_d     = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (en_i) begin
                state_d = S_RUN;
            end
        end else begin
            if (cnt_q == half_q - ONE) begin
                toggle    = 1'b1;
                cnt_d     = '0;
                clk_out_d = ~clk_out_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
            fall = toggle & clk_out_q;

            // A re-raised enable wins over the stop boundary so the output never gaps.
            if (state_q == S_RUN) begin
                if (!en_i) begin
                    state_d = S_STOP;
                end
            end else if (en_i) begin
                state_d = S_RUN;
            end else if (fall) begin
                state_d = S_IDLE;
            end
        end

        tick_d  = toggle;
        pdone_d = fall;

        if (fall && pending_q) begin
            half_d    = pend_q;
            pending_d = 1'b0;
        end

        // A transfer needs pending low, so it never collides with the apply above.
        if (xfer) begin
            if (cfg_half_i == '0) begin
                err_d = 1'b1;
            end else if (state_q == S_IDLE) begin
                half_d = cfg_half_i;
            end else begin
                pend_d    = cfg_half_i;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            half_q    <= HALF_RST;
            pend_q    <= '0;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            pdone_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            pdone_q   <= pdone_d;
            err_q     <= err_d;
        end
    end

    assign cfg_ready_o   = ~pending_q;
    assign cfg_err_o     = err_q;
    assign clk_out_o     = clk_out_q;
    assign tick_o        = tick_q;
    assign period_done_o = pdone_q;
    assign running_o     = (state_q != S_IDLE);
    assign pending_o     = pending_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic, each cycle
// compared against an event-level model (countdown to next toggle, queued config).
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_half = 8'd0;
    logic       cfg_ready, cfg_err, clk_out, tick, period_done, running, pending;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_ctrl #(.CNT_W(8), .DEFAULT_HALF(3)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .cfg_valid_i  (cfg_valid),
        .cfg_half_i   (cfg_half),
        .cfg_ready_o  (cfg_ready),
        .cfg_err_o    (cfg_err),
        .clk_out_o    (clk_out),
        .tick_o       (tick),
        .period_done_o(period_done),
        .running_o    (running),
        .pending_o    (pending)
    );

    always #5 clk = ~clk;

    // Reference model: active/stopping flags, output level, edges left until the
    // next toggle, current half period and a queue holding at most one new ratio.
    bit m_active, m_stop, m_lvl, m_tick, m_pd, m_err;
    int m_rem, m_half;
    int m_pq[$];

    task automatic model_reset();
        m_active = 0; m_stop = 0; m_lvl = 0;
        m_tick = 0; m_pd = 0; m_err = 0;
        m_rem = 0; m_half = 3;
        m_pq.delete();
    endtask

    task automatic model_edge();
        bit xfer, was_idle, tog, fall;
        tog = 0; fall = 0;
        if (rst) begin
            model_reset();
            return;
        end
        xfer = cfg_valid && (m_pq.size() == 0);
        was_idle = !m_active;
        m_tick = 0; m_pd = 0; m_err = 0;
        if (xfer && cfg_half == 0) m_err = 1;
        if (was_idle) begin
            if (xfer && cfg_half != 0) m_half = cfg_half;
            if (en) begin
                m_active = 1; m_stop = 0; m_lvl = 0; m_rem = m_half;
            end
        end else begin
            m_rem = m_rem - 1;
            tog = (m_rem == 0);
            fall = tog && m_lvl;
            if (tog) begin
                m_lvl = !m_lvl;
                m_tick = 1;
                if (fall) begin
                    m_pd = 1;
                    if (m_pq.size() > 0) m_half = m_pq.pop_front();
                end
                m_rem = m_half;
            end
            if (!m_stop) begin
                if (!en) m_stop = 1;
            end else if (en) begin
                m_stop = 0;
            end else if (fall) begin
                m_active = 0;
            end
            if (xfer && cfg_half != 0) m_pq.push_back(cfg_half);
        end
    endtask

    function automatic logic [6:0] obs();
        return {clk_out, tick, period_done, cfg_err, running, pending, cfg_ready};
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_lvl, m_tick, m_pd, m_err, m_active, (m_pq.size() != 0), (m_pq.size() == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        en = 0; cfg_valid = 0; cfg_half = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs() !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=%b", obs(), 7'b0000001);
        end
        step();
        n_tests++;
        if (obs() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle got=%b want=%b", obs(), exp_vec());
        end
    endtask

    task automatic test_default_run();
        int rise_at, fall_at, ticks, pds;
        do_reset();
        rise_at = -1; fall_at = -1; ticks = 0; pds = 0;
        en = 1;
        step();
        for (int k = 1; k <= 24; k++) begin
            step();
            n_tests++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL default_run cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
            if (clk_out && rise_at < 0) rise_at = k;
            if (!clk_out && rise_at > 0 && fall_at < 0) fall_at = k;
            ticks += tick;
            pds += period_done;
        end
        n_tests++;
        if (rise_at != 3 || fall_at != 6) begin
            n_fail++;
            $display("FAIL default_edges rise=%0d fall=%0d want rise=3 fall=6", rise_at, fall_at);
        end
        n_tests++;
        if (ticks != 8 || pds != 4) begin
            n_fail++;
            $display("FAIL default_pulses ticks=%0d pdone=%0d want 8 and 4", ticks, pds);
        end
    endtask

    task automatic test_idle_cfg();
        int rise_at, saw_pend;
        do_reset();
        rise_at = -1; saw_pend = 0;
        cfg_valid = 1; cfg_half = 8'd5; en = 1;
        step();
        cfg_valid = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            n_tests++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_cfg cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
            if (clk_out && rise_at < 0) rise_at = k;
            saw_pend |= pending;
        end
        n_tests++;
        if (rise_at != 5 || saw_pend != 0) begin
            n_fail++;
            $display("FAIL idle_cfg_rise rise=%0d pending_seen=%0d want rise=5 pending_seen=0", rise_at, saw_pend);
        end
    endtask

    task automatic test_reconfig();
        int guard, toggles;
        logic prev;
        do_reset();
        en = 1;
        guard = 0;
        while (!clk_out && guard < 20) begin step(); guard++; end
        step();
        cfg_valid = 1; cfg_half = 8'd1;
        step();
        cfg_valid = 0;
        n_tests++;
        if (cfg_ready !== 1'b0 || guard >= 20) begin
            n_fail++;
            $display("FAIL reconfig_ready got=%b want=0 guard=%0d", cfg_ready, guard);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            n_tests++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reconfig cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
        toggles = 0;
        prev = clk_out;
        for (int k = 0; k < 6; k++) begin
            step();
            if (clk_out != prev) toggles++;
            prev = clk_out;
        end
        n_tests++;
        if (toggles != 6) begin
            n_fail++;
            $display("FAIL reconfig_div2 toggles=%0d want 6", toggles);
        end
    endtask

    task automatic test_busy_and_zero();
        int guard;
        do_reset();
        en = 1;
        step(); step();
        cfg_valid = 1; cfg_half = 8'd4;
        step();
        cfg_half = 8'd7;
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++;
            if (cfg_ready !== 1'b0 || pending !== 1'b1 || obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL busy_block got=%b want=%b", obs(), exp_vec());
            end
        end
        cfg_valid = 0;
        guard = 0;
        while (pending && guard < 20) begin
            step();
            guard++;
            n_tests++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL busy_drain got=%b want=%b", obs(), exp_vec());
            end
        end
        n_tests++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL busy_timeout pending=%b want 0", pending);
        end
        cfg_valid = 1; cfg_half = 8'd0;
        step();
        cfg_valid = 0;
        n_tests++;
        if (cfg_err !== 1'b1 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_err err=%b pending=%b want err=1 pending=0", cfg_err, pending);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            n_tests++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL zero_after cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_stop();
        int guard, dropped;
        do_reset();
        en = 1;
        // Low phase drop, then high phase drop; each must finish its period.
        for (int phase = 0; phase < 2; phase++) begin
            guard = 0;
            while (clk_out != phase[0] && guard < 20) begin step(); guard++; end
            if (phase == 0) begin step(); step(); end
            en = 0;
            dropped = 0;
            while ((running || dropped == 0) && guard < 40) begin
                step();
                guard++;
                dropped = 1;
                n_tests++;
                if (obs() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL stop_ph%0d got=%b want=%b", phase, obs(), exp_vec());
                end
            end
            n_tests++;
            if (guard >= 40 || clk_out !== 1'b0 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_idle_ph%0d clk_out=%b running=%b want 0 0", phase, clk_out, running);
            end
            en = 1;
            step();
        end
        guard = 0;
        while (!clk_out && guard < 20) begin step(); guard++; end
        en = 0;
        step(); step();
        en = 1;
        for (int k = 0; k < 15; k++) begin
            step();
            n_tests++;
            if (obs() !== exp_vec() || running !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_resume cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int guard, rise_at;
        do_reset();
        en = 1;
        guard = 0;
        while (!clk_out && guard < 20) begin step(); guard++; end
        cfg_valid = 1; cfg_half = 8'd9;
        step();
        cfg_valid = 0;
        en = 0;
        #2 rst = 1;
        #1;
        model_reset();
        n_tests++;
        if (obs() !== 7'b0000001) begin
            n_fail++;
            $display("FAIL async_reset got=%b want=%b", obs(), 7'b0000001);
        end
        @(posedge clk);
        #1 rst = 0;
        en = 1;
        step();
        rise_at = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (clk_out && rise_at < 0) rise_at = k;
        end
        n_tests++;
        if (rise_at != 3) begin
            n_fail++;
            $display("FAIL async_reset_half rise=%0d want 3", rise_at);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_half = 8'($urandom_range(0, 6));
            step();
            n_tests++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b want=%b", k, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_run();
        test_idle_cfg();
        test_reconfig();
        test_busy_and_zero();
        test_stop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
